// File: rtl/incdec_stage_pkg.sv
// Shared bus encodings for the increment/decrement stage: master instruction
// codes, controller state codes and operation select codes.
package incdec_stage_pkg;

  // Master port instruction codes
  localparam logic [1:0] INSTR_IDLE  = 2'b00;
  localparam logic [1:0] INSTR_WRITE = 2'b10;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_DELAY = 2'b01;
  localparam logic [1:0] ST_SEND  = 2'b10;

  // Operation select; 2'b11 behaves as pass-through
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;

endpackage

// File: rtl/bin27.sv
// Hex nibble to seven-segment decoder, active-high segments {g,f,e,d,c,b,a}.
module bin27 (
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  // Pure lookup of the sixteen hex glyphs
  always_comb begin
    seg = 7'h00;
    case (bin)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO. The caller must not push when full without a
// simultaneous pop, nor pop when empty.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/incdec_stage.sv
// Bus application stage: queues slave writes, displays the current word,
// applies add/sub/pass after a hold delay and retransmits on the master port.
module incdec_stage
  import incdec_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DELAY_COUNT = 20,
  parameter int unsigned STEP        = 1,
  parameter int unsigned TX_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_switch,
  input  logic [1:0]            op_sel,
  input  logic                  button,
  input  logic [DATA_W-1:0]     sw_array_data,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_write_en_in,
  input  logic                  m_tx_done,
  output logic [DATA_W-1:0]     m_data_out,
  output logic [1:0]            m_instruction,
  output logic [7*DATA_W/4-1:0] display_pins,
  output logic                  fifo_full,
  output logic                  overflow_err,
  output logic                  tx_timeout_err
);

  localparam int unsigned   TW        = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);
  localparam logic [15:0]   DelayMax  = 16'(DELAY_COUNT);
  localparam logic [TW-1:0] TxMax     = TW'(TX_TIMEOUT);
  localparam logic [DATA_W-1:0] StepVal = DATA_W'(STEP);

  logic [1:0]        state;
  logic [DATA_W-1:0] cur_data;
  logic [15:0]       delay_cnt;
  logic [TW-1:0]     tx_cnt;
  logic              btn_prev;
  logic              btn_rise;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] op_result;

  // Pop only when IDLE has nothing of higher priority (button load) to do
  always_comb begin
    fifo_pop  = (state == ST_IDLE) && mode_switch && !btn_rise && !fifo_empty;
    fifo_push = s_write_en_in && mode_switch && (!fifo_full || fifo_pop);
  end

  // Selected arithmetic, modulo 2^DATA_W by truncation
  always_comb begin
    op_result = cur_data;
    case (op_sel)
      OP_ADD:  op_result = cur_data + StepVal;
      OP_SUB:  op_result = cur_data - StepVal;
      OP_PASS: op_result = cur_data;
      default: op_result = cur_data;
    endcase
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Registered rising-edge detect of the button level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      btn_prev <= button;
      btn_rise <= button & ~btn_prev;
    end
  end

  // Sticky flag for writes dropped against a full queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (s_write_en_in && mode_switch && fifo_full && !fifo_pop) begin
      overflow_err <= 1'b1;
    end
  end

  // Controller: IDLE -> DELAY -> SEND, or IDLE -> SEND on a button press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cur_data       <= '0;
      delay_cnt      <= '0;
      tx_cnt         <= '0;
      m_data_out     <= '0;
      m_instruction  <= INSTR_IDLE;
      tx_timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_rise && mode_switch) begin
            cur_data      <= sw_array_data;
            m_data_out    <= sw_array_data;
            m_instruction <= INSTR_WRITE;
            tx_cnt        <= '0;
            state         <= ST_SEND;
          end else if (fifo_pop) begin
            cur_data  <= fifo_rdata;
            delay_cnt <= '0;
            state     <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (delay_cnt == DelayMax) begin
            cur_data      <= op_result;
            m_data_out    <= op_result;
            m_instruction <= INSTR_WRITE;
            tx_cnt        <= '0;
            state         <= ST_SEND;
          end else begin
            delay_cnt <= delay_cnt + 16'd1;
          end
        end
        ST_SEND: begin
          if (m_tx_done) begin
            m_instruction <= INSTR_IDLE;
            state         <= ST_IDLE;
          end else if (tx_cnt == TxMax) begin
            // Word is abandoned; the next queued word proceeds normally
            m_instruction  <= INSTR_IDLE;
            tx_timeout_err <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One decoder per nibble, digit 0 in the low bits
  for (genvar i = 0; i < DATA_W / 4; i++) begin : g_digit
    bin27 u_bin27 (
      .bin (cur_data[4*i +: 4]),
      .seg (display_pins[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_incdec_stage.sv
// Self-checking bench for incdec_stage: directed timing/boundary checks plus
// randomized bursts scored against a transaction-level reference.
module tb_incdec_stage;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DLY   = 4;
  localparam int unsigned TMO   = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode_switch = 1'b0;
  logic [1:0]    op_sel = 2'b00;
  logic          button = 1'b0;
  logic [DW-1:0] sw_array_data = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_write_en_in = 1'b0;
  logic          m_tx_done = 1'b0;
  logic [DW-1:0] m_data_out;
  logic [1:0]    m_instruction;
  logic [13:0]   display_pins;
  logic          fifo_full;
  logic          overflow_err;
  logic          tx_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  incdec_stage #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .DELAY_COUNT (DLY),
    .STEP        (1),
    .TX_TIMEOUT  (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode_switch    (mode_switch),
    .op_sel         (op_sel),
    .button         (button),
    .sw_array_data  (sw_array_data),
    .s_data         (s_data),
    .s_write_en_in  (s_write_en_in),
    .m_tx_done      (m_tx_done),
    .m_data_out     (m_data_out),
    .m_instruction  (m_instruction),
    .display_pins   (display_pins),
    .fifo_full      (fifo_full),
    .overflow_err   (overflow_err),
    .tx_timeout_err (tx_timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  function automatic logic [13:0] disp(input logic [7:0] x);
    return {seg7(x[7:4]), seg7(x[3:0])};
  endfunction

  // Reference arithmetic: plain modulo-256 add/sub/pass
  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] w);
    int r;
    if (op == 2'b00)      r = int'(w) + 1;
    else if (op == 2'b01) r = int'(w) + 255;
    else                  r = int'(w);
    return 8'(r % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] w);
    s_data = w;
    s_write_en_in = 1'b1;
    tick();
    s_write_en_in = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int k = 0;
    while (m_instruction !== 2'b10 && k < budget) begin
      tick();
      k++;
    end
    check_eq("req_seen", 32'(m_instruction == 2'b10), 32'd1);
  endtask

  task automatic ack(input int dly);
    repeat (dly) tick();
    m_tx_done = 1'b1;
    tick();
    m_tx_done = 1'b0;
    check_eq("ack_idle", 32'(m_instruction), 32'd0);
  endtask

  task automatic count_req(input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      tick();
      if (m_instruction == 2'b10) hits++;
    end
  endtask

  task automatic run_word(input logic [1:0] op, input logic [7:0] w, input string tag);
    logic [7:0] e;
    e = ref_op(op, w);
    op_sel = op;
    write_word(w);
    wait_req(DLY + 8);
    check_eq({tag, "_data"}, 32'(m_data_out), 32'(e));
    check_eq({tag, "_disp"}, 32'(display_pins), 32'(disp(e)));
    ack(0);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] w;
    logic [7:0] e;
    logic       exp_ovf;
    logic [1:0] op;
    logic       md;
    int         n;
    int         hits;
    int         k;

    // Reset state
    #12;
    check_eq("rst_instr", 32'(m_instruction), 32'd0);
    check_eq("rst_data", 32'(m_data_out), 32'd0);
    check_eq("rst_full", 32'(fifo_full), 32'd0);
    check_eq("rst_ovf", 32'(overflow_err), 32'd0);
    check_eq("rst_tmo", 32'(tx_timeout_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mode_switch = 1'b1;
    tick();

    // Exact latency: write at edge 0, request right after edge DLY+2
    op_sel = 2'b00;
    write_word(8'h3C);
    repeat (DLY + 1) tick();
    check_eq("lat_pre", 32'(m_instruction), 32'd0);
    tick();
    check_eq("lat_instr", 32'(m_instruction), 32'd2);
    check_eq("lat_data", 32'(m_data_out), 32'h3D);
    m_tx_done = 1'b1;
    tick();
    m_tx_done = 1'b0;
    check_eq("lat_ack", 32'(m_instruction), 32'd0);
    tick();

    // Wrap-around and pass-through
    run_word(2'b01, 8'h00, "sub_wrap");
    run_word(2'b00, 8'hFF, "add_wrap");
    run_word(2'b10, 8'h5A, "pass");
    run_word(2'b11, 8'h5A, "op11");

    // Button: sent unmodified after two edges, held level does not repeat
    op_sel = 2'b00;
    sw_array_data = 8'hA5;
    button = 1'b1;
    tick();
    check_eq("btn_edge1", 32'(m_instruction), 32'd0);
    tick();
    check_eq("btn_instr", 32'(m_instruction), 32'd2);
    check_eq("btn_data", 32'(m_data_out), 32'hA5);
    ack(1);
    count_req(10, hits);
    check_eq("btn_norepeat", 32'(hits), 32'd0);
    button = 1'b0;
    tick();

    // Randomized bursts against a transaction-level queue model
    exp_ovf = 1'b0;
    for (int t = 0; t < 14; t++) begin
      op = 2'($urandom_range(0, 3));
      md = ($urandom_range(0, 4) != 0);
      n  = $urandom_range(1, 7);
      op_sel = op;
      mode_switch = md;
      q.delete();
      // From idle: one word goes straight to the controller, DEPTH more queue up
      for (int i = 0; i < n; i++) begin
        w = 8'($urandom);
        s_data = w;
        s_write_en_in = 1'b1;
        if (md && i < int'(DEPTH) + 1) q.push_back(ref_op(op, w));
        tick();
      end
      s_write_en_in = 1'b0;
      if (md && n > int'(DEPTH) + 1) exp_ovf = 1'b1;
      if (!md) begin
        count_req(12, hits);
        check_eq("rnd_off_nosend", 32'(hits), 32'd0);
      end
      while (q.size() > 0) begin
        e = q.pop_front();
        wait_req(DLY + 12);
        check_eq("rnd_data", 32'(m_data_out), 32'(e));
        ack($urandom_range(0, 4));
      end
      tick();
      tick();
      check_eq("rnd_ovf", 32'(overflow_err), 32'(exp_ovf));
      check_eq("rnd_tmo", 32'(tx_timeout_err), 32'd0);
      check_eq("rnd_full", 32'(fifo_full), 32'd0);
    end
    mode_switch = 1'b1;

    // Overflow: six back-to-back writes, sixth dropped, order preserved
    op_sel = 2'b10;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'(8'h10 + i);
      s_write_en_in = 1'b1;
      tick();
    end
    s_write_en_in = 1'b0;
    check_eq("ovf_full", 32'(fifo_full), 32'd1);
    check_eq("ovf_flag", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_req(DLY + 12);
      check_eq("ovf_order", 32'(m_data_out), 32'(8'h10 + i));
      ack(1);
    end
    tick();
    check_eq("ovf_drained", 32'(fifo_full), 32'd0);

    // Transmit timeout, then the queued word still goes out
    write_word(8'h11);
    write_word(8'h22);
    wait_req(DLY + 12);
    check_eq("tmo_first", 32'(m_data_out), 32'h11);
    k = 0;
    while (m_instruction == 2'b10 && k < 60) begin
      tick();
      k++;
    end
    check_eq("tmo_cycles", 32'(k), 32'(TMO + 1));
    check_eq("tmo_flag", 32'(tx_timeout_err), 32'd1);
    wait_req(DLY + 12);
    check_eq("tmo_next", 32'(m_data_out), 32'h22);
    ack(0);
    tick();

    // Reset mid-DELAY with words queued
    op_sel = 2'b00;
    write_word(8'h31);
    write_word(8'h32);
    write_word(8'h33);
    #3 reset = 1'b1;
    #1;
    check_eq("rstd_instr", 32'(m_instruction), 32'd0);
    check_eq("rstd_data", 32'(m_data_out), 32'd0);
    check_eq("rstd_ovf", 32'(overflow_err), 32'd0);
    check_eq("rstd_tmo", 32'(tx_timeout_err), 32'd0);
    check_eq("rstd_disp", 32'(display_pins), 32'(disp(8'h00)));
    @(posedge clk);
    #1 reset = 1'b0;
    count_req(15, hits);
    check_eq("rstd_empty", 32'(hits), 32'd0);

    // Reset mid-SEND
    write_word(8'h77);
    wait_req(DLY + 12);
    check_eq("rsts_pre", 32'(m_data_out), 32'h78);
    #3 reset = 1'b1;
    #1;
    check_eq("rsts_instr", 32'(m_instruction), 32'd0);
    check_eq("rsts_data", 32'(m_data_out), 32'd0);
    check_eq("rsts_full", 32'(fifo_full), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    count_req(10, hits);
    check_eq("rsts_quiet", 32'(hits), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
